// File: rtl/gpio_pkg.sv
// gpio_pkg: shared GPIO sizing defaults and interrupt edge-mode encoding
package gpio_pkg;
  localparam int GPIO_WIDTH = 16;
  localparam int GPIO_DB_W = 8;
  localparam int GPIO_SYNC_STAGES = 2;
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;
  function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
    return (mode[0] & rise) | (mode[1] & fall);
  endfunction
endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin synchroniser, debounce filter and edge event generation
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int DB_W = GPIO_DB_W,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            db_en,
  input  logic [DB_W-1:0] db_len,
  output logic            level,
  output logic            rise,
  output logic            fall
);
  logic [SYNC_STAGES-1:0] sy;
  logic [DB_W-1:0] cnt;
  logic sync;
  logic upd;
  assign sync = sy[SYNC_STAGES-1];
  always_comb begin
    upd = (sync != level) && (!db_en || cnt >= db_len);
    rise = upd & sync;
    fall = upd & ~sync;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sy <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sy <= {sy[SYNC_STAGES-2:0], din};
      level <= upd ? sync : level;
      cnt <= (upd || !db_en || sync == level) ? '0 : (&cnt ? cnt : cnt + 1'b1);
    end
  end
endmodule

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: GPIO input conditioning with edge-triggered interrupt pending bits
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter int DB_W = GPIO_DB_W,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] r_db_en,
  input  logic [DB_W-1:0]  r_db_len,
  input  logic [WIDTH-1:0] r_int_en,
  input  logic [WIDTH-1:0] r_int_rise,
  input  logic [WIDTH-1:0] r_int_fall,
  input  logic [WIDTH-1:0] int_clr,
  output logic [WIDTH-1:0] gpio_val,
  output logic [WIDTH-1:0] int_pend,
  output logic             irq
);
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_filter #(
      .DB_W(DB_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_filter (
      .clk(clk),
      .rst(rst),
      .din(gpio_in[i]),
      .db_en(r_db_en[i]),
      .db_len(r_db_len),
      .level(gpio_val[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
    assign set[i] = r_int_en[i] & edge_hit(edge_mode_e'({r_int_fall[i], r_int_rise[i]}), rise[i], fall[i]);
  end
  always_ff @(posedge clk) begin
    int_pend <= rst ? '0 : set | (int_pend & ~int_clr);
  end
  assign irq = |int_pend;
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: directed scoreboard bench for GPIO input conditioning
module tb_gpio_in_cond;
  typedef enum logic [1:0] {S_VAL, S_PEND, S_IRQ} sig_e;
  typedef struct {
    int at;
    sig_e sig;
    logic [15:0] mask;
    logic [15:0] exp;
    string tag;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] gpio_in = '0;
  logic [15:0] r_db_en = '0;
  logic [7:0] r_db_len = '0;
  logic [15:0] r_int_en = '0;
  logic [15:0] r_int_rise = '0;
  logic [15:0] r_int_fall = '0;
  logic [15:0] int_clr = '0;
  logic [15:0] gpio_val;
  logic [15:0] int_pend;
  logic irq;
  item_t sb[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  gpio_in_cond dut (
    .clk(clk),
    .rst(rst),
    .gpio_in(gpio_in),
    .r_db_en(r_db_en),
    .r_db_len(r_db_len),
    .r_int_en(r_int_en),
    .r_int_rise(r_int_rise),
    .r_int_fall(r_int_fall),
    .int_clr(int_clr),
    .gpio_val(gpio_val),
    .int_pend(int_pend),
    .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic expect_at(input int d, input sig_e s, input int pin, input logic v, input string tag);
    item_t it;
    it.at = cyc + d;
    it.sig = s;
    it.mask = (s == S_IRQ) ? 16'h0001 : (pin < 0 ? 16'hffff : 16'h0001 << pin);
    it.exp = {16{v}} & it.mask;
    it.tag = tag;
    sb.push_back(it);
  endtask
  task automatic tick(input int n = 1);
    logic [15:0] obs;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          obs = (sb[j].sig == S_VAL ? gpio_val : sb[j].sig == S_PEND ? int_pend : {15'b0, irq}) & sb[j].mask;
          n_assert++;
          assert (obs === sb[j].exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", sb[j].tag, cyc, obs, sb[j].exp);
          end
          sb.delete(j);
        end
      end
    end
  endtask
  initial begin
    expect_at(1, S_VAL, -1, 1'b0, "rst_val");
    expect_at(1, S_PEND, -1, 1'b0, "rst_pend");
    expect_at(1, S_IRQ, 0, 1'b0, "rst_irq");
    tick(2);
    rst = 1'b0;
    gpio_in[0] = 1'b1;
    expect_at(2, S_VAL, 0, 1'b0, "byp_early");
    expect_at(3, S_VAL, 0, 1'b1, "byp_lat3");
    expect_at(4, S_PEND, 0, 1'b0, "byp_no_int");
    tick(5);
    r_db_en[1] = 1'b1;
    r_db_len = 8'd4;
    gpio_in[1] = 1'b1;
    for (int d = 3; d <= 9; d++) expect_at(d, S_VAL, 1, 1'b0, "glitch_rej");
    tick(3);
    gpio_in[1] = 1'b0;
    tick(7);
    gpio_in[1] = 1'b1;
    expect_at(6, S_VAL, 1, 1'b0, "db_early");
    expect_at(7, S_VAL, 1, 1'b1, "db_lat7");
    tick(10);
    r_int_en[2] = 1'b1;
    r_int_rise[2] = 1'b1;
    gpio_in[2] = 1'b1;
    expect_at(2, S_PEND, 2, 1'b0, "rise_early");
    expect_at(3, S_VAL, 2, 1'b1, "rise_val");
    expect_at(3, S_PEND, 2, 1'b1, "rise_pend");
    expect_at(3, S_IRQ, 0, 1'b1, "rise_irq");
    tick(4);
    int_clr[2] = 1'b1;
    expect_at(1, S_PEND, 2, 1'b0, "clr_pend");
    expect_at(1, S_IRQ, 0, 1'b0, "clr_irq");
    tick();
    int_clr[2] = 1'b0;
    gpio_in[2] = 1'b0;
    expect_at(3, S_VAL, 2, 1'b0, "fall_val");
    expect_at(3, S_PEND, 2, 1'b0, "fall_ignored");
    expect_at(4, S_IRQ, 0, 1'b0, "fall_irq");
    tick(5);
    r_int_fall[2] = 1'b1;
    gpio_in[2] = 1'b1;
    expect_at(3, S_PEND, 2, 1'b1, "any_rise");
    tick(4);
    int_clr[2] = 1'b1;
    expect_at(1, S_PEND, 2, 1'b0, "any_clr");
    tick();
    int_clr[2] = 1'b0;
    gpio_in[2] = 1'b0;
    expect_at(2, S_PEND, 2, 1'b0, "any_fall_early");
    expect_at(3, S_PEND, 2, 1'b1, "any_fall");
    tick(4);
    int_clr[2] = 1'b1;
    tick();
    int_clr[2] = 1'b0;
    r_int_en[3] = 1'b1;
    r_int_rise[3] = 1'b1;
    gpio_in[3] = 1'b1;
    expect_at(3, S_PEND, 3, 1'b1, "collide_set_wins");
    expect_at(3, S_IRQ, 0, 1'b1, "collide_irq");
    expect_at(4, S_PEND, 3, 1'b0, "late_clr");
    expect_at(4, S_IRQ, 0, 1'b0, "late_clr_irq");
    tick(2);
    int_clr[3] = 1'b1;
    tick(2);
    int_clr[3] = 1'b0;
    r_int_en[3] = 1'b0;
    tick(2);
    r_int_en[3] = 1'b1;
    r_db_en[4] = 1'b1;
    r_db_len = 8'd8;
    gpio_in[4] = 1'b1;
    tick(5);
    rst = 1'b1;
    expect_at(1, S_VAL, -1, 1'b0, "midrst_val");
    expect_at(1, S_PEND, -1, 1'b0, "midrst_pend");
    expect_at(1, S_IRQ, 0, 1'b0, "midrst_irq");
    tick();
    rst = 1'b0;
    expect_at(3, S_VAL, 0, 1'b1, "post_rst_byp");
    expect_at(3, S_PEND, 3, 1'b1, "post_rst_pend");
    expect_at(10, S_VAL, 4, 1'b0, "post_rst_db_early");
    expect_at(11, S_VAL, 4, 1'b1, "post_rst_db_lat");
    tick(12);
    r_db_en[5] = 1'b1;
    r_db_len = 8'd20;
    gpio_in[5] = 1'b1;
    expect_at(12, S_VAL, 5, 1'b0, "len_cnt10");
    tick(12);
    r_db_len = 8'd3;
    expect_at(1, S_VAL, 5, 1'b1, "len_lowered");
    tick(3);
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
